// File: rtl/sha256_job_arbiter_if.sv
// sha256_job_arbiter_if: requester-side and engine-side signals of the
// SHA-256 job arbiter, grouped with arbiter (master) / environment (slave) views.
//
// Ports carried:
//   req, req_msg_addr, req_out_addr : per-requester job level and addresses
//   gnt, ack, err                   : one-hot grant, done pulse, timeout pulse
//   core_start, core_message_addr,
//   core_output_addr, core_done     : engine start pulse, latched addresses, idle level
//   busy                            : arbiter not idle
interface sha256_job_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_msg_addr;
  logic [16*NUM_REQ-1:0] req_out_addr;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    err;
  logic                  core_start;
  logic [15:0]           core_message_addr;
  logic [15:0]           core_output_addr;
  logic                  core_done;
  logic                  busy;

  modport master (
    input  req, req_msg_addr, req_out_addr, core_done,
    output gnt, ack, err, core_start,
    output core_message_addr, core_output_addr, busy
  );

  modport slave (
    output req, req_msg_addr, req_out_addr, core_done,
    input  gnt, ack, err, core_start,
    input  core_message_addr, core_output_addr, busy
  );
endinterface

// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter: round-robin arbiter handing one SHA-256 engine
// to NUM_REQ requesters, one job at a time, all outputs registered.
//
// Ports: clk, reset_n (async active-low), bus (sha256_job_arbiter_if.master).
// Optional macro SHA_ARB_TIMEOUT_EN adds a per-job watchdog that pulses
// err[winner] after TIMEOUT_CYCLES in WAIT_LOW/WAIT_HIGH; without it err is 0.
module sha256_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                  clk,
  input logic                  reset_n,
  sha256_job_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;

  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
  end

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [15:0]        msg_q, msg_d;
  logic [15:0]        out_q, out_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      win_q, win_d;
  logic [IW-1:0]      pick;
  logic               found;

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [WDW-1:0]     wd_q, wd_d;
`endif

  // First requesting index above last winner, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    start_d = 1'b0;
    msg_d   = msg_q;
    out_d   = out_q;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.core_done && found) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          msg_d       = bus.req_msg_addr[16*int'(pick) +: 16];
          out_d       = bus.req_out_addr[16*int'(pick) +: 16];
          state_d     = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!bus.core_done) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (bus.core_done) begin
          ack_d   = gnt_q;
          gnt_d   = '0;
          last_d  = win_q;
          state_d = S_ACK;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SHA_ARB_TIMEOUT_EN
    err_d = '0;
    wd_d  = wd_q;
    if (state_q == S_START) begin
      wd_d = '0;
    end else if (state_q == S_WAIT_LOW ||
                 (state_q == S_WAIT_HIGH && !bus.core_done)) begin
      wd_d = wd_q + 1'b1;
      // A completing job beats the watchdog on the same edge.
      if (wd_d == WDW'(TIMEOUT_CYCLES)) begin
        err_d   = gnt_q;
        gnt_d   = '0;
        last_d  = win_q;
        state_d = S_IDLE;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      msg_q   <= '0;
      out_q   <= '0;
      last_q  <= LAST_RST;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
      wd_q  <= '0;
    end else begin
      err_q <= err_d;
      wd_q  <= wd_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = '0;
`endif

  assign bus.gnt               = gnt_q;
  assign bus.ack               = ack_q;
  assign bus.core_start        = start_q;
  assign bus.core_message_addr = msg_q;
  assign bus.core_output_addr  = out_q;
  assign bus.busy              = busy_q;
endmodule

// File: doc/sha256_job_arbiter.md
SHA256_JOB_ARBITER -- requirements
Module: sha256_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SHA-256 engine, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in clk cycles per job (used only when SHA_ARB_TIMEOUT_EN is defined).
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  NUM_REQ  per-requester job request level.
REQ-006 req_msg_addr  in  16*NUM_REQ  per-requester message word address; slice i is bits [16i+15:16i].
REQ-007 req_out_addr  in  16*NUM_REQ  per-requester hash output word address; slice i is bits [16i+15:16i].
REQ-008 gnt  out  NUM_REQ  one-hot grant, held for the whole job.
REQ-009 ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 err  out  NUM_REQ  one-cycle timeout pulse; constant 0 when SHA_ARB_TIMEOUT_EN is undefined.
REQ-011 core_start  out  1  start pulse to the engine.
REQ-012 core_message_addr  out  16  latched message address of the granted job.
REQ-013 core_output_addr  out  16  latched output address of the granted job.
REQ-014 core_done  in  1  engine idle level: high while the engine idles, low while it runs.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT_LOW, WAIT_HIGH and ACK; every output SHALL be registered.
REQ-017 In IDLE with core_done=1 and any req bit high, the block SHALL select a winner round-robin, searching upward from last_winner+1 modulo NUM_REQ.
REQ-018 On that edge the block SHALL set gnt to the winner's one-hot value, latch the winner's two addresses into core_message_addr and core_output_addr, and move to START.
REQ-019 In IDLE with core_done=0, the block SHALL issue no grant, whatever the req inputs.
REQ-020 In START, core_start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_LOW.
REQ-021 In WAIT_LOW, the block SHALL remain until core_done is sampled 0, then move to WAIT_HIGH.
REQ-022 In WAIT_HIGH, the block SHALL remain until core_done is sampled 1, then move to ACK.
REQ-023 In ACK, for one cycle: ack[winner]=1, gnt=0, last_winner updated to the winner, next state IDLE.
REQ-024 Timing: req seen in IDLE at edge N -> gnt high after edge N, core_start high in cycle N+1 -> N+2; ack follows the core_done rise by exactly one cycle.
REQ-025 core_message_addr and core_output_addr SHALL stay constant from grant until the next grant.
REQ-026 A req drop during a job SHALL be ignored; the job completes and is acknowledged.
REQ-027 A req still high after its ack SHALL be treated as a new job that competes round-robin; starvation-free with at most NUM_REQ-1 jobs served before any waiting requester.
REQ-028 A req rising in the same cycle as ACK SHALL be considered only in the following IDLE cycle.

Reset
REQ-029 While reset_n=0, the block SHALL hold: state=IDLE, gnt=0, ack=0, err=0, core_start=0, both core addresses=0, busy=0, watchdog=0, last_winner=NUM_REQ-1 (so requester 0 has first priority).
REQ-030 Reset asserted mid-job SHALL abort immediately with no ack or err; after release, no grant SHALL issue until core_done=1.

Configuration
REQ-031 With SHA_ARB_TIMEOUT_EN defined: the watchdog clears on entry to WAIT_LOW and increments each cycle in WAIT_LOW and WAIT_HIGH.
REQ-032 With SHA_ARB_TIMEOUT_EN defined: when the watchdog reaches TIMEOUT_CYCLES, the block SHALL pulse err[winner] instead of ack, clear gnt, update last_winner and return to IDLE.
REQ-033 With SHA_ARB_TIMEOUT_EN undefined: no watchdog logic, err tied to 0, and the block waits indefinitely.

Verification
REQ-034 The bench SHALL cover: reset, req=0001, addrs 0x0000/0x0100, model done low for 200 cycles -> gnt=0001 next cycle, one core_start, addrs 0x0000/0x0100, ack[0] one cycle after done rises.
REQ-035 The bench SHALL cover: req=1111 held continuously -> grant order 0,1,2,3,0, with exactly one ack per job.
REQ-036 The bench SHALL cover: req[2] dropped during WAIT_HIGH -> job completes, ack[2] pulses, and no re-grant to 2.
REQ-037 The bench SHALL cover: core_done held 0 out of reset with req=0011 -> gnt stays 0 until done=1, then gnt=0001.
REQ-038 The bench SHALL cover: with SHA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16 and done never rising -> err[winner] at watchdog 16, no ack, and the next grant after done=1.
REQ-039 The bench SHALL cover: reset_n pulsed low in WAIT_HIGH -> all outputs 0 the same cycle, and no ack.
